// File: rtl/ahb_arbiter_rr.sv
// Round-robin AHB bus arbiter: one-hot registered HGRANT held across fixed-length
// bursts and locked sequences, plus registered HMASTER/HMASTLOCK for the address mux.
module ahb_arbiter_rr #(
   parameter int NUM_MST = 4,
   parameter int DEF_MST = 0
) (
   input  logic               HCLK,
   input  logic               HRESETn,
   input  logic [NUM_MST-1:0] HBUSREQ,
   input  logic [NUM_MST-1:0] HLOCK,
   input  logic [1:0]         HTRANS,
   input  logic [2:0]         HBURST,
   input  logic               HREADY,
   output logic [NUM_MST-1:0] HGRANT,
   output logic [3:0]         HMASTER,
   output logic               HMASTLOCK
);

   localparam logic [NUM_MST-1:0] DEF_OH  = NUM_MST'(1) << DEF_MST;
   localparam logic [3:0]         DEF_IDX = 4'(DEF_MST);

   typedef enum logic {ARB, BURST} state_e;

   state_e             state_q, state_d;
   logic [NUM_MST-1:0] grant_q, grant_d;
   logic [3:0]         ptr_q, ptr_d;
   logic [3:0]         master_q, master_d;
   logic               mastLock_q, mastLock_d;
   logic [4:0]         rem_q, rem_d;

   logic [4:0]         burstLen;
   logic               nonseqAcc, seqAcc, arbAllowed, lockHold, anyReq;
   logic [NUM_MST-1:0] reqRot, ownerOh, winnerOh;
   logic [4:0]         offset, winnerSum;
   logic [3:0]         winner, grantIdx;

   always_comb begin
      unique case (HBURST)
         3'b010, 3'b011: burstLen = 5'd4;
         3'b100, 3'b101: burstLen = 5'd8;
         3'b110, 3'b111: burstLen = 5'd16;
         default:        burstLen = 5'd1;
      endcase
   end

   assign nonseqAcc = HREADY && (HTRANS == 2'b10);
   assign seqAcc    = HREADY && (HTRANS == 2'b11);

   // Rotate requests so bit 0 is the master just after the last grant; the lowest set bit wins.
   always_comb begin
      reqRot = NUM_MST'({HBUSREQ, HBUSREQ} >> ({1'b0, ptr_q} + 5'd1));
      anyReq = |HBUSREQ;
      offset = '0;
      for (int j = NUM_MST - 1; j >= 0; j--) begin
         if (reqRot[j]) offset = 5'(j);
      end
      winnerSum = {1'b0, ptr_q} + 5'd1 + offset;
      if (winnerSum >= 5'(NUM_MST)) winnerSum = winnerSum - 5'(NUM_MST);
      winner = winnerSum[3:0];
   end

   always_comb begin
      grantIdx = DEF_IDX;
      ownerOh  = '0;
      winnerOh = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         ownerOh[i]  = (master_q == 4'(i));
         winnerOh[i] = (winner == 4'(i));
         if (grant_q[i]) grantIdx = 4'(i);
      end
   end

   assign lockHold = |(HLOCK & HBUSREQ & ownerOh);

   // Inside a burst the only arbitration point is the accepted last beat, giving early handoff.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      arbAllowed = 1'b0;
      if (nonseqAcc)
         rem_d = burstLen - 5'd1;
      else if (seqAcc && (rem_q != 5'd0))
         rem_d = rem_q - 5'd1;
      unique case (state_q)
         ARB: begin
            arbAllowed = HREADY;
            if (nonseqAcc && (burstLen != 5'd1)) state_d = BURST;
         end
         BURST: begin
            if (nonseqAcc) begin
               if (burstLen == 5'd1) state_d = ARB;
            end else if (seqAcc && (rem_q == 5'd1)) begin
               arbAllowed = 1'b1;
               state_d    = ARB;
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_comb begin
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      master_d   = master_q;
      mastLock_d = mastLock_q;
      if (arbAllowed && !lockHold) begin
         if (anyReq) begin
            grant_d = winnerOh;
            ptr_d   = winner;
         end else begin
            grant_d = DEF_OH;
         end
      end
      if (HREADY) begin
         master_d   = grantIdx;
         mastLock_d = |(HLOCK & grant_q);
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= ARB;
         grant_q    <= DEF_OH;
         ptr_q      <= DEF_IDX;
         master_q   <= DEF_IDX;
         mastLock_q <= 1'b0;
         rem_q      <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         master_q   <= master_d;
         mastLock_q <= mastLock_d;
         rem_q      <= rem_d;
      end
   end

   assign HGRANT    = grant_q;
   assign HMASTER   = master_q;
   assign HMASTLOCK = mastLock_q;

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Self-checking bench for ahb_arbiter_rr: directed scenarios plus random traffic,
// all compared against a behavioural model of the arbitration rules.
module tb_ahb_arbiter_rr;

   localparam int N = 4;
   localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
   localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011, INCR8 = 3'b101, WRAP16 = 3'b110;

   logic         HCLK = 1'b0;
   logic         HRESETn;
   logic [N-1:0] HBUSREQ, HLOCK, HGRANT;
   logic [1:0]   HTRANS;
   logic [2:0]   HBURST;
   logic         HREADY;
   logic [3:0]   HMASTER;
   logic         HMASTLOCK;

   int errors = 0;
   int checks = 0;

   // Model state: granted master, address-phase owner, its lock flag, beats left, last winner.
   int mGrant, mMaster, mRem, mPtr;
   bit mLock;

   ahb_arbiter_rr #(.NUM_MST(N), .DEF_MST(0)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
      .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY),
      .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
   );

   always #5 HCLK = ~HCLK;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic modelReset();
      mGrant = 0; mMaster = 0; mLock = 0; mRem = 0; mPtr = 0;
   endtask

   task automatic checkConst(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic checkTrue(input string tag, input bit cond);
      checks++;
      assert (cond === 1'b1) else begin
         errors++;
         $error("[TB] FAIL %s observed=0 expected=1", tag);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [3:0] expGrant, expMaster;
      expGrant  = 4'b0001 << mGrant;
      expMaster = 4'(mMaster);
      checks++;
      assert (HGRANT === expGrant) else begin
         errors++;
         $error("[TB] FAIL %s.grant observed=%b expected=%b", tag, HGRANT, expGrant);
      end
      checks++;
      assert (HMASTER === expMaster) else begin
         errors++;
         $error("[TB] FAIL %s.master observed=%0d expected=%0d", tag, HMASTER, expMaster);
      end
      checks++;
      assert (HMASTLOCK === mLock) else begin
         errors++;
         $error("[TB] FAIL %s.mastlock observed=%b expected=%b", tag, HMASTLOCK, mLock);
      end
   endtask

   // Owner behaviour: continue a burst, else start a transfer if still requesting.
   function automatic logic [1:0] autoTrans(input logic [3:0] req);
      if (mRem != 0) return SEQ;
      if (req[mMaster]) return NONSEQ;
      return IDLE;
   endfunction

   // Drive one cycle, predict the next state from the arbitration rules, then check after the edge.
   task automatic applyStimulus(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                                input logic [2:0] burst, input logic ready, input string tag);
      int nGrant, nPtr, nMaster, len, idx;
      bit nLock, found, isSeq, isNonseq, allowed;
      HBUSREQ = req; HLOCK = lock; HTRANS = trans; HBURST = burst; HREADY = ready;
      nGrant = mGrant; nPtr = mPtr; nMaster = mMaster; nLock = mLock;
      isNonseq = ready && (trans == NONSEQ);
      isSeq    = ready && (trans == SEQ);
      len = (int'(burst) < 2) ? 1 : (4 << ((int'(burst) - 2) / 2));
      allowed = ready && ((mRem == 0) || (isSeq && mRem == 1));
      if (allowed && !(lock[mMaster] && req[mMaster])) begin
         nGrant = 0;
         found  = 0;
         for (int k = 1; k <= N; k++) begin
            idx = (mPtr + k) % N;
            if (!found && req[idx]) begin
               found = 1; nGrant = idx; nPtr = idx;
            end
         end
      end
      if (ready) begin
         nMaster = mGrant;
         nLock   = lock[mGrant];
      end
      @(posedge HCLK);
      #1;
      if (isNonseq) mRem = len - 1;
      else if (isSeq && mRem > 0) mRem = mRem - 1;
      mGrant = nGrant; mPtr = nPtr; mMaster = nMaster; mLock = nLock;
      checkOutput(tag);
   endtask

   initial begin
      logic [3:0] req, lock;
      logic [1:0] tr;
      logic [2:0] burst;
      logic       rdy;
      int beat, waits, guard;
      int order [5] = '{1, 2, 3, 0, 1};

      HRESETn = 1'b0; HBUSREQ = '0; HLOCK = '0; HTRANS = IDLE; HBURST = SINGLE; HREADY = 1'b0;
      modelReset();
      #12;
      checkConst("reset.grant", HGRANT, 4'b0001);
      checkConst("reset.master", HMASTER, 4'd0);
      checkConst("reset.mastlock", {3'b000, HMASTLOCK}, 4'd0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(posedge HCLK);
      #1;

      $display("[TB] idle after reset");
      for (int c = 0; c < 20; c++) begin
         applyStimulus(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, "idle");
         checkConst("idle.grant", HGRANT, 4'b0001);
      end

      $display("[TB] M1/M2 single transfers");
      for (int c = 0; c < 8; c++) begin
         applyStimulus(4'b0110, 4'b0000, autoTrans(4'b0110), SINGLE, 1'b1, "alt");
         checkConst("alt.grant", HGRANT, (c % 2 == 0) ? 4'b0010 : 4'b0100);
      end

      $display("[TB] M2 INCR8 with wait states, M3 requests at beat 2");
      guard = 0;
      while (mMaster != 2 && guard < 10) begin
         applyStimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, "toM2");
         guard++;
      end
      checkTrue("toM2.bound", mMaster == 2);
      beat = 0; waits = 0; guard = 0;
      while (beat < 8 && guard < 40) begin
         guard++;
         req = (beat >= 1) ? 4'b1100 : 4'b0100;
         rdy = 1'b1;
         if (beat == 3 && waits < 3) begin
            rdy = 1'b0;
            waits++;
         end
         tr = autoTrans(req);
         if (rdy && tr[1] && mMaster == 2) beat++;
         applyStimulus(req, 4'b0000, tr, INCR8, rdy, "incr8");
         if (beat < 8) checkConst("incr8.hold", HGRANT, 4'b0100);
      end
      checkTrue("incr8.bound", beat == 8);
      checkConst("incr8.handoff", HGRANT, 4'b1000);
      guard = 0;
      while ((mRem != 0 || guard < 3) && guard < 30) begin
         applyStimulus(4'b0000, 4'b0000, autoTrans(4'b0000), SINGLE, 1'b1, "drain");
         guard++;
      end

      $display("[TB] M0 locked INCR4 bursts with M1 requesting");
      guard = 0;
      while (mMaster != 0 && guard < 10) begin
         applyStimulus(4'b0001, 4'b0001, IDLE, SINGLE, 1'b1, "toM0");
         guard++;
      end
      checkTrue("toM0.bound", mMaster == 0);
      for (int c = 0; c < 10; c++) begin
         applyStimulus(4'b0011, 4'b0001, autoTrans(4'b0011), INCR4, 1'b1, "lock");
         checkConst("lock.grant", HGRANT, 4'b0001);
         checkConst("lock.mastlock", {3'b000, HMASTLOCK}, 4'd1);
      end
      guard = 0;
      while (mGrant != 1 && guard < 12) begin
         applyStimulus(4'b0011, 4'b0000, autoTrans(4'b0011), INCR4, 1'b1, "unlock");
         guard++;
      end
      checkConst("unlock.grant", HGRANT, 4'b0010);

      $display("[TB] reset during WRAP16");
      beat = 0; guard = 0;
      while (beat < 4 && guard < 30) begin
         tr = autoTrans(4'b0010);
         if (tr[1] && mMaster == 1) beat++;
         applyStimulus(4'b0010, 4'b0000, tr, WRAP16, 1'b1, "wrap16");
         guard++;
      end
      checkTrue("wrap16.bound", beat == 4);
      HTRANS = autoTrans(4'b0010);
      #2;
      HRESETn = 1'b0;
      #1;
      checkConst("midreset.grant", HGRANT, 4'b0001);
      checkConst("midreset.master", HMASTER, 4'd0);
      checkConst("midreset.mastlock", {3'b000, HMASTLOCK}, 4'd0);
      modelReset();
      HBUSREQ = '0; HLOCK = '0; HTRANS = IDLE; HBURST = SINGLE; HREADY = 1'b0;
      @(posedge HCLK);
      #1;
      checkConst("inreset.grant", HGRANT, 4'b0001);
      HRESETn = 1'b1;
      for (int c = 0; c < 10; c++)
         applyStimulus(4'b0100, 4'b0000, autoTrans(4'b0100), INCR4, 1'b1, "postreset");

      $display("[TB] all masters request singles");
      HRESETn = 1'b0;
      modelReset();
      HBUSREQ = '0; HLOCK = '0; HTRANS = IDLE; HBURST = SINGLE; HREADY = 1'b0;
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      for (int c = 0; c < 5; c++) begin
         applyStimulus(4'b1111, 4'b0000, autoTrans(4'b1111), SINGLE, 1'b1, "rr4");
         checkConst("rr4.order", HGRANT, 4'b0001 << order[c]);
      end

      $display("[TB] random traffic");
      for (int c = 0; c < 400; c++) begin
         req   = 4'($urandom_range(0, 15));
         lock  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         rdy   = ($urandom_range(0, 4) != 0);
         burst = 3'($urandom_range(0, 7));
         tr    = autoTrans(req);
         if (tr == SEQ && $urandom_range(0, 7) == 0) tr = BUSY;
         applyStimulus(req, lock, tr, burst, rdy, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
